// File: rtl/credit_rx_fifo.sv
// Credit-controlled receive buffer: NumCredits entries, one credit returned per pop.
// Data visible one cycle after push; no ready upstream, overflowing pushes are dropped and flagged.
module credit_rx_fifo #(
  parameter int unsigned NumCredits      = 4,
  parameter int unsigned DataWidth       = 32,
  parameter bit          RegCreditReturn = 1'b1,
  localparam int unsigned CntWidth       = $clog2(NumCredits + 1),
  localparam int unsigned PtrWidth       = (NumCredits > 1) ? $clog2(NumCredits) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 valid_i,
  input  logic [DataWidth-1:0] data_i,
  output logic                 valid_o,
  output logic [DataWidth-1:0] data_o,
  input  logic                 ready_i,
  output logic                 credit_give_o,
  output logic [CntWidth-1:0]  usage_o,
  output logic                 overflow_o
);

  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(NumCredits - 1);
  localparam logic [CntWidth-1:0] FullCnt = CntWidth'(NumCredits);

  logic [DataWidth-1:0] mem [NumCredits];
  logic [PtrWidth-1:0]  rd_ptr, wr_ptr;
  logic [CntWidth-1:0]  usage;
  logic                 pop, push, drop;

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    valid_o = (usage != '0) && !flush_i;
    pop     = valid_o && ready_i;
    push    = valid_i && !flush_i && ((usage < FullCnt) || pop);
    drop    = valid_i && !flush_i && !push;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      usage      <= '0;
      overflow_o <= 1'b0;
    end else if (flush_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      usage      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      usage <= usage + 1'b1;
      else if (pop && !push) usage <= usage - 1'b1;
      if (drop) overflow_o <= 1'b1;
    end
  end

  // Storage needs no reset: valid_o gates every read.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  assign data_o  = mem[rd_ptr];
  assign usage_o = usage;

  if (RegCreditReturn) begin : g_reg_credit
    logic credit_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) credit_q <= 1'b0;
      else         credit_q <= pop;
    end
    // A flush cancels the pulse owed for the previous cycle's pop.
    assign credit_give_o = credit_q && !flush_i;
  end else begin : g_comb_credit
    assign credit_give_o = pop;
  end

endmodule

// File: tb/tb_credit_rx_fifo.sv
// Directed bench: instance A (4 credits, registered credit), instance B (3 credits, combinational credit).
module tb_credit_rx_fifo;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        fa, va, ra, vo_a, cg_a, ov_a;
  logic [31:0] da, do_a;
  logic [2:0]  us_a;

  logic        fb, vb, rb, vo_b, cg_b, ov_b;
  logic [31:0] db, do_b;
  logic [1:0]  us_b;

  credit_rx_fifo #(.NumCredits(4), .DataWidth(32), .RegCreditReturn(1'b1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fa), .valid_i(va), .data_i(da),
    .valid_o(vo_a), .data_o(do_a), .ready_i(ra), .credit_give_o(cg_a),
    .usage_o(us_a), .overflow_o(ov_a)
  );

  credit_rx_fifo #(.NumCredits(3), .DataWidth(32), .RegCreditReturn(1'b0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fb), .valid_i(vb), .data_i(db),
    .valid_o(vo_b), .data_o(do_b), .ready_i(rb), .credit_give_o(cg_b),
    .usage_o(us_b), .overflow_o(ov_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_a(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      va = 1'b1;
      da = base + 32'(i);
      #1 chk("fill_a_no_credit", 32'(cg_a), 32'd0);
      tick();
    end
    va = 1'b0;
  endtask

  int credits_b;

  initial begin
    rst_n = 1'b0;
    {fa, va, ra, fb, vb, rb} = '0;
    da = '0;
    db = '0;
    #12;
    chk("rst_usage_a", 32'(us_a), 32'd0);
    chk("rst_valid_a", 32'(vo_a), 32'd0);
    chk("rst_credit_a", 32'(cg_a), 32'd0);
    chk("rst_ovf_a", 32'(ov_a), 32'd0);
    chk("rst_usage_b", 32'(us_b), 32'd0);
    rst_n = 1'b1;
    tick();

    // Fill with ready low, then drain in order with credits one cycle after each pop.
    fill_a(32'hA0, 4);
    #1;
    chk("full_usage", 32'(us_a), 32'd4);
    chk("full_valid", 32'(vo_a), 32'd1);
    chk("full_head", do_a, 32'hA0);
    chk("full_no_credit", 32'(cg_a), 32'd0);
    for (int i = 0; i < 4; i++) begin
      ra = 1'b1;
      #1;
      chk("drain_data", do_a, 32'hA0 + 32'(i));
      chk("drain_valid", 32'(vo_a), 32'd1);
      chk("drain_credit", 32'(cg_a), (i > 0) ? 32'd1 : 32'd0);
      tick();
    end
    ra = 1'b0;
    #1;
    chk("drain_last_credit", 32'(cg_a), 32'd1);
    chk("drain_empty_usage", 32'(us_a), 32'd0);
    chk("drain_empty_valid", 32'(vo_a), 32'd0);
    tick();
    chk("drain_credit_done", 32'(cg_a), 32'd0);

    // Push into a full buffer while popping: accepted behind older entries.
    fill_a(32'hB0, 4);
    va = 1'b1; da = 32'hC0; ra = 1'b1;
    #1;
    chk("pp_head", do_a, 32'hB0);
    chk("pp_usage_before", 32'(us_a), 32'd4);
    tick();
    va = 1'b0;
    #1;
    chk("pp_usage_after", 32'(us_a), 32'd4);
    chk("pp_no_ovf", 32'(ov_a), 32'd0);
    chk("pp_credit", 32'(cg_a), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("pp_order", do_a, (i == 3) ? 32'hC0 : 32'hB1 + 32'(i));
      tick();
    end
    ra = 1'b0;
    #1 chk("pp_empty", 32'(us_a), 32'd0);

    // Push into a full buffer with no pop: dropped, overflow flagged.
    tick();
    fill_a(32'hD0, 4);
    va = 1'b1; da = 32'hFF;
    tick();
    va = 1'b0;
    #1;
    chk("ovf_flag", 32'(ov_a), 32'd1);
    chk("ovf_usage", 32'(us_a), 32'd4);
    chk("ovf_head", do_a, 32'hD0);
    chk("ovf_no_credit", 32'(cg_a), 32'd0);
    ra = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("ovf_drain", do_a, 32'hD0 + 32'(i));
      tick();
    end
    ra = 1'b0;
    #1;
    chk("ovf_drop_empty", 32'(vo_a), 32'd0);
    chk("ovf_sticky", 32'(ov_a), 32'd1);
    tick();

    // Pop, then flush next cycle: pending credit cancelled, state cleared.
    fill_a(32'hE0, 2);
    ra = 1'b1;
    #1 chk("fl_pop_valid", 32'(vo_a), 32'd1);
    tick();
    fa = 1'b1; va = 1'b1; da = 32'h77;
    #1;
    chk("fl_credit_cancel", 32'(cg_a), 32'd0);
    chk("fl_valid_forced", 32'(vo_a), 32'd0);
    tick();
    fa = 1'b0; va = 1'b0;
    #1;
    chk("fl_usage", 32'(us_a), 32'd0);
    chk("fl_valid", 32'(vo_a), 32'd0);
    chk("fl_ovf_clear", 32'(ov_a), 32'd0);
    chk("fl_credit_after", 32'(cg_a), 32'd0);
    ra = 1'b0;
    tick();

    // Reset mid-operation right after a pop: no credit emitted.
    fill_a(32'hF0, 2);
    ra = 1'b1;
    tick();
    ra = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_credit", 32'(cg_a), 32'd0);
    chk("mrst_usage", 32'(us_a), 32'd0);
    chk("mrst_valid", 32'(vo_a), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("mrst_credit_after", 32'(cg_a), 32'd0);

    // Combinational credit coincides with the pop.
    vb = 1'b1; db = 32'h55;
    tick();
    vb = 1'b0;
    #1;
    chk("cc_valid", 32'(vo_b), 32'd1);
    chk("cc_no_credit", 32'(cg_b), 32'd0);
    rb = 1'b1;
    #1;
    chk("cc_credit_same", 32'(cg_b), 32'd1);
    chk("cc_data", do_b, 32'h55);
    tick();
    rb = 1'b0;
    #1;
    chk("cc_credit_done", 32'(cg_b), 32'd0);
    chk("cc_empty", 32'(us_b), 32'd0);

    // Ten streaming cycles through three entries: pointers wrap, order held.
    credits_b = 0;
    rb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vb = 1'b1;
      db = 32'h10 + 32'(i);
      #1;
      if (cg_b) credits_b++;
      if (i > 0) chk("wrap_data", do_b, 32'h10 + 32'(i - 1));
      tick();
    end
    vb = 1'b0;
    #1;
    chk("wrap_last", do_b, 32'h19);
    if (cg_b) credits_b++;
    tick();
    chk("wrap_credits", 32'(credits_b), 32'd10);
    chk("wrap_empty", 32'(us_b), 32'd0);
    rb = 1'b0;

    // Fill the three-entry instance and overflow it.
    for (int i = 0; i < 4; i++) begin
      vb = 1'b1;
      db = 32'h30 + 32'(i);
      tick();
    end
    vb = 1'b0;
    #1;
    chk("b_full_usage", 32'(us_b), 32'd3);
    chk("b_ovf", 32'(ov_b), 32'd1);
    chk("b_head", do_b, 32'h30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/credit_rx_fifo.md
CREDIT_RX_FIFO -- requirements
Module: credit_rx_fifo

Interface
- REQ-001: Parameter NumCredits, default 4, number of buffer entries and credits granted to the upstream sender; SHALL be >= 1 and need not be a power of two.
- REQ-002: Parameter DataWidth, default 32, payload width in bits.
- REQ-003: Parameter RegCreditReturn, default 1'b1; 1 = credit pulse registered, 0 = credit pulse combinational with pop.
- REQ-004: Derived CntWidth = $clog2(NumCredits+1); PtrWidth = max(1, $clog2(NumCredits)).
- REQ-005: clk_i  input  1  sole clock, rising edge.
- REQ-006: rst_ni  input  1  asynchronous active-low reset.
- REQ-007: flush_i  input  1  synchronous soft-reset of buffer contents, issued together with the sender's credit re-initialization.
- REQ-008: valid_i  input  1  push strobe from the credit-controlled link; no ready is returned.
- REQ-009: data_i  input  DataWidth  push payload.
- REQ-010: valid_o  output  1  downstream valid.
- REQ-011: data_o  output  DataWidth  head-of-buffer payload.
- REQ-012: ready_i  input  1  downstream ready.
- REQ-013: credit_give_o  output  1  one-cycle pulse returning one credit to the sender's give input.
- REQ-014: usage_o  output  CntWidth  current number of occupied entries.
- REQ-015: overflow_o  output  1  sticky error: a push arrived with no free entry.

Function
- REQ-016: Storage SHALL be a circular buffer of NumCredits entries with read and write pointers wrapping from NumCredits-1 to 0.
- REQ-017: Pop SHALL occur when valid_o && ready_i.
- REQ-018: Push SHALL be accepted when valid_i && !flush_i && (usage < NumCredits || pop in the same cycle).
- REQ-019: Push with usage == NumCredits and no pop SHALL drop the data, leave state unchanged and set overflow_o on the next edge.
- REQ-020: Pushed data SHALL appear on data_o no earlier than the cycle after the push; no combinational path from valid_i/data_i to outputs.
- REQ-021: valid_o SHALL equal (usage_o != 0); data_o SHALL be the entry at the read pointer and SHALL be stable while valid_o && !ready_i.
- REQ-022: usage_o next value = usage + push - pop; simultaneous push and pop leaves usage unchanged.
- REQ-023: Each pop SHALL produce exactly one credit_give_o pulse: same cycle when RegCreditReturn = 0, the following cycle when RegCreditReturn = 1.
- REQ-024: Dropped pushes (REQ-019) SHALL NOT return credits.
- REQ-025: flush_i high SHALL, on the next edge, set both pointers and usage_o to 0 and clear overflow_o; flush_i has priority over push and pop.
- REQ-026: While flush_i is high, valid_o SHALL be forced to 0 and no pop SHALL occur; credit_give_o SHALL be 0 in that cycle, and a registered credit pulse pending from the prior cycle SHALL be cancelled.
- REQ-027: Total credit pulses SHALL never exceed total accepted pushes since the last reset/flush.

Reset
- REQ-028: On rst_ni low, asynchronously: pointers = 0, usage_o = 0, valid_o = 0, credit_give_o = 0, overflow_o = 0; storage contents need not be reset.
- REQ-029: Reset asserted mid-operation SHALL discard all entries and pending credit pulses without emitting any credit_give_o pulse.

Verification
- REQ-030: NumCredits=4, RegCreditReturn=1, ready_i=0, 4 pushes 0xA0..0xA3 -> usage_o=4, valid_o=1, data_o=0xA0, no credit pulses; then ready_i=1 for 4 cycles -> data_o 0xA0..0xA3 in order, 4 credit_give_o pulses each one cycle after its pop.
- REQ-031: Full (usage 4), ready_i=0, push 0xFF -> overflow_o=1 next cycle, usage_o stays 4, 0xFF never appears on data_o.
- REQ-032: Full, ready_i=1 and valid_i=1 same cycle -> usage_o stays 4, overflow_o stays 0, pushed word popped after the 3 older entries.
- REQ-033: NumCredits=3 (non power of two), 10 push/pop cycles continuous -> pointers wrap 2->0, output order equals input order, 10 credit pulses total.
- REQ-034: usage_o=2, pop in cycle N with RegCreditReturn=1, flush_i=1 in cycle N+1 -> credit_give_o=0 in N+1, usage_o=0 and valid_o=0 in N+2, overflow_o cleared.
- REQ-035: RegCreditReturn=0, single push then pop with ready_i=1 -> credit_give_o high in the same cycle as valid_o && ready_i.
